// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the instruction/data memory bus arbiter: the FSM
//   state encoding, the default bus timeout and the data value returned when
//   a transaction is ended by timeout instead of by an acknowledge.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Arbiter states (3-bit encoding).
  typedef enum logic [2:0] {
    ArbIdle   = 3'd0,
    ArbBusyIf = 3'd1,
    ArbBusyDm = 3'd2,
    ArbDoneIf = 3'd3,
    ArbDoneDm = 3'd4
  } arb_state_e;

  // Cycles a BUSY state may wait for mem_ack_i before giving up.
  localparam int ArbTimeoutDefault = 16;

  // Data returned to the requesting port after a timeout.
  localparam logic [31:0] ArbErrData = 32'h0;

  // Instruction fetches always read a full word.
  localparam logic [3:0] ArbFetchSel = 4'b1111;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory bus between the instruction-fetch port and
//   the data-memory port of the 5-stage core. Data accesses win over fetches.
//   Each granted request becomes one bus transaction that ends on mem_ack_i or
//   after TIMEOUT cycles without an acknowledge (bus_err_o pulses). The result
//   is presented in a one-cycle DONE state, during which the port's stall
//   request drops.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   if_ce_i/addr_i    fetch request (level) and address
//   if_data_o         fetched instruction (registered)
//   if_stallreq_o     fetch not yet complete
//   dm_ce_i/we_i/sel_i/addr_i/data_i   data request, write flag, byte enables,
//                     address, write data
//   dm_data_o         read data (registered, unchanged by writes)
//   dm_stallreq_o     data access not yet complete
//   mem_ce_o/we_o/sel_o/addr_o/data_o  registered bus request
//   mem_data_i        bus read data, valid with mem_ack_i
//   mem_ack_i         one-cycle bus completion
//   bus_err_o         one-cycle pulse during the DONE cycle after a timeout
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ArbTimeoutDefault,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_stallreq_o,

  input  logic        dm_ce_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_i,
  output logic [31:0] dm_data_o,
  output logic        dm_stallreq_o,

  output logic        mem_ce_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i,

  output logic        bus_err_o
);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_expired;
  logic             in_busy;

  assign in_busy     = (state == ArbBusyIf) || (state == ArbBusyDm);
  assign cnt_expired = (cnt == CNT_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ArbIdle;
    else      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ArbIdle: begin
        if (dm_ce_i)      state_nxt = ArbBusyDm;
        else if (if_ce_i) state_nxt = ArbBusyIf;
      end
      ArbBusyIf: if (mem_ack_i || cnt_expired) state_nxt = ArbDoneIf;
      ArbBusyDm: if (mem_ack_i || cnt_expired) state_nxt = ArbDoneDm;
      // DONE lasts exactly one cycle; requests seen here belong to the access
      // that just completed.
      ArbDoneIf: state_nxt = ArbIdle;
      ArbDoneDm: state_nxt = ArbIdle;
      default:   state_nxt = ArbIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timeout counter: counts un-acknowledged BUSY cycles, zero everywhere else.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (in_busy && !mem_ack_i && !cnt_expired) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus request, result and error registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ce_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_sel_o  <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      if_data_o  <= '0;
      dm_data_o  <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      unique case (state)
        ArbIdle: begin
          if (dm_ce_i) begin
            mem_ce_o   <= 1'b1;
            mem_we_o   <= dm_we_i;
            mem_sel_o  <= dm_sel_i;
            mem_addr_o <= dm_addr_i;
            mem_data_o <= dm_data_i;
          end else if (if_ce_i) begin
            mem_ce_o   <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_sel_o  <= ArbFetchSel;
            mem_addr_o <= if_addr_i;
            mem_data_o <= '0;
          end
        end

        ArbBusyIf, ArbBusyDm: begin
          if (mem_ack_i || cnt_expired) begin
            // The bus cannot abort, so the result is latched even if the
            // requester has since dropped its request (pipeline flush).
            if (mem_ack_i) begin
              if (state == ArbBusyIf)  if_data_o <= mem_data_i;
              else if (!mem_we_o)      dm_data_o <= mem_data_i;
            end else begin
              if (state == ArbBusyIf)  if_data_o <= ArbErrData;
              else                     dm_data_o <= ArbErrData;
              bus_err_o <= 1'b1;
            end
            mem_ce_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_sel_o  <= '0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
          end
        end

        default: ; // DONE states: outputs hold, bus already idle
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stall requests: held until the port's DONE cycle; forced low in reset.
  // ---------------------------------------------------------------------------
  assign if_stallreq_o = rst & if_ce_i & (state != ArbDoneIf);
  assign dm_stallreq_o = rst & dm_ce_i & (state != ArbDoneDm);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Inputs change 1 ns after a rising edge;
//   outputs are sampled 1 ns after the inputs settle, well clear of the edge.
//   "Cycle n" below starts at the n-th rising edge after a scenario begins.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        dm_ce_i;
  logic        dm_we_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_i;
  logic [31:0] dm_data_o;
  logic        dm_stallreq_o;
  logic        mem_ce_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic        bus_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_ce_i       (if_ce_i),
    .if_addr_i     (if_addr_i),
    .if_data_o     (if_data_o),
    .if_stallreq_o (if_stallreq_o),
    .dm_ce_i       (dm_ce_i),
    .dm_we_i       (dm_we_i),
    .dm_sel_i      (dm_sel_i),
    .dm_addr_i     (dm_addr_i),
    .dm_data_i     (dm_data_i),
    .dm_data_o     (dm_data_o),
    .dm_stallreq_o (dm_stallreq_o),
    .mem_ce_o      (mem_ce_o),
    .mem_we_o      (mem_we_o),
    .mem_sel_o     (mem_sel_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .bus_err_o     (bus_err_o)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_ce_i = 1'b1; if_addr_i = 32'h0;
    dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'h0; dm_addr_i = 32'h0; dm_data_i = 32'h0;
    mem_data_i = 32'h0; mem_ack_i = 1'b0;
    tick(); tick();
    #1;
    checks++;
    if ({mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o} !== 70'h0) begin
      errors++; $display("FAIL reset_bus: got ce=%b addr=%h, want all zero", mem_ce_o, mem_addr_o);
    end
    checks++;
    if ({if_data_o, dm_data_o, bus_err_o} !== 65'h0) begin
      errors++; $display("FAIL reset_data: got if=%h dm=%h err=%b, want 0", if_data_o, dm_data_o, bus_err_o);
    end
    checks++;
    if ({if_stallreq_o, dm_stallreq_o} !== 2'b00) begin
      errors++; $display("FAIL reset_stall: got %b%b, want 00", if_stallreq_o, dm_stallreq_o);
    end
    if_ce_i = 1'b0; dm_ce_i = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    // cycle 0: request
    if_ce_i = 1'b1; if_addr_i = 32'h100;
    #1;
    checks++;
    if (if_stallreq_o !== 1'b1) begin
      errors++; $display("FAIL fetch_stall_c0: got %b, want 1", if_stallreq_o);
    end
    tick(); // cycle 1
    checks++;
    if ({mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      errors++; $display("FAIL fetch_bus_c1: got ce=%b we=%b sel=%h addr=%h, want 1 0 f 00000100",
                         mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h3C010101;
    tick(); // cycle 2
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    #1;
    checks++;
    if (if_data_o !== 32'h3C010101) begin
      errors++; $display("FAIL fetch_data_c2: got %h, want 3c010101", if_data_o);
    end
    checks++;
    if ({if_stallreq_o, mem_ce_o} !== 2'b00) begin
      errors++; $display("FAIL fetch_done_c2: got stall=%b ce=%b, want 0 0", if_stallreq_o, mem_ce_o);
    end
    if_ce_i = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    // cycle 0: both request
    dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h2000; dm_data_i = 32'h0;
    if_ce_i = 1'b1; if_addr_i = 32'h104;
    tick(); // cycle 1
    checks++;
    if (mem_addr_o !== 32'h2000) begin
      errors++; $display("FAIL prio_dm_first: got addr=%h, want 00002000", mem_addr_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'hDEADBEEF;
    tick(); // cycle 2: DONE_DM
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if ({dm_stallreq_o, if_stallreq_o, dm_data_o} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL prio_c2: got dms=%b ifs=%b dm=%h, want 0 1 deadbeef",
                         dm_stallreq_o, if_stallreq_o, dm_data_o);
    end
    dm_ce_i = 1'b0;
    tick(); // cycle 3: IDLE grants fetch
    checks++;
    if ({mem_ce_o, if_stallreq_o} !== 2'b01) begin
      errors++; $display("FAIL prio_c3: got ce=%b ifs=%b, want 0 1", mem_ce_o, if_stallreq_o);
    end
    tick(); // cycle 4
    checks++;
    if ({mem_ce_o, mem_addr_o} !== {1'b1, 32'h104}) begin
      errors++; $display("FAIL prio_fetch_c4: got ce=%b addr=%h, want 1 00000104", mem_ce_o, mem_addr_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h11112222;
    tick(); // cycle 5
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if ({if_stallreq_o, if_data_o} !== {1'b0, 32'h11112222}) begin
      errors++; $display("FAIL prio_fetch_c5: got ifs=%b if=%h, want 0 11112222", if_stallreq_o, if_data_o);
    end
    if_ce_i = 1'b0;
    tick();
  endtask

  task automatic test_dm_write();
    dm_ce_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0011; dm_addr_i = 32'h2004; dm_data_i = 32'hA5A5A5A5;
    tick(); // cycle 1
    checks++;
    if ({mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o} !==
        {1'b1, 1'b1, 4'b0011, 32'h2004, 32'hA5A5A5A5}) begin
      errors++; $display("FAIL write_bus: got ce=%b we=%b sel=%b addr=%h data=%h, want 1 1 0011 00002004 a5a5a5a5",
                         mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'hFFFF0000;
    tick(); // cycle 2
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if ({dm_stallreq_o, dm_data_o} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL write_keeps_data: got dms=%b dm=%h, want 0 deadbeef", dm_stallreq_o, dm_data_o);
    end
    dm_ce_i = 1'b0; dm_we_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int busy_cycles;
    busy_cycles = 0;
    if_ce_i = 1'b1; if_addr_i = 32'h200;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (mem_ce_o === 1'b1 && if_stallreq_o === 1'b1 && bus_err_o === 1'b0) busy_cycles++;
    end
    checks++;
    if (busy_cycles !== 16) begin
      errors++; $display("FAIL timeout_busy_len: got %0d busy cycles, want 16", busy_cycles);
    end
    tick(); // DONE_IF after timeout
    checks++;
    if ({bus_err_o, if_data_o, mem_ce_o, if_stallreq_o} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_done: got err=%b if=%h ce=%b ifs=%b, want 1 00000000 0 0",
                         bus_err_o, if_data_o, mem_ce_o, if_stallreq_o);
    end
    if_ce_i = 1'b0;
    tick(); // back in IDLE
    checks++;
    if ({bus_err_o, mem_ce_o} !== 2'b00) begin
      errors++; $display("FAIL timeout_idle: got err=%b ce=%b, want 0 0", bus_err_o, mem_ce_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h3000;
    tick(); // cycle 1: BUSY_DM
    checks++;
    if (mem_ce_o !== 1'b1) begin
      errors++; $display("FAIL rstmid_busy: got ce=%b, want 1", mem_ce_o);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_ce_o, mem_addr_o, dm_data_o, if_data_o, dm_stallreq_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL rstmid_async: got ce=%b addr=%h dm=%h if=%h dms=%b, want all 0",
                         mem_ce_o, mem_addr_o, dm_data_o, if_data_o, dm_stallreq_o);
    end
    dm_ce_i = 1'b0;
    tick();
    rst = 1'b1;
    mem_ack_i = 1'b1; mem_data_i = 32'h55555555; // late ack
    tick();
    mem_ack_i = 1'b0;
    tick();
    checks++;
    if ({mem_ce_o, dm_data_o, bus_err_o} !== {1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL rstmid_late_ack: got ce=%b dm=%h err=%b, want 0 00000000 0",
                         mem_ce_o, dm_data_o, bus_err_o);
    end
    // Still IDLE: a fresh fetch must be granted on the very next edge.
    if_ce_i = 1'b1; if_addr_i = 32'h300;
    tick();
    checks++;
    if ({mem_ce_o, mem_addr_o} !== {1'b1, 32'h300}) begin
      errors++; $display("FAIL rstmid_idle: got ce=%b addr=%h, want 1 00000300", mem_ce_o, mem_addr_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h0;
    tick();
    mem_ack_i = 1'b0; if_ce_i = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    int stall_seen;
    stall_seen = 0;
    dm_ce_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h4000;
    if_ce_i = 1'b1; if_addr_i = 32'h108;
    tick(); // cycle 1: BUSY_DM, then flush
    dm_ce_i = 1'b0;
    #1;
    if (dm_stallreq_o !== 1'b0) stall_seen++;
    checks++;
    if ({mem_ce_o, mem_addr_o} !== {1'b1, 32'h4000}) begin
      errors++; $display("FAIL flush_bus: got ce=%b addr=%h, want 1 00004000", mem_ce_o, mem_addr_o);
    end
    tick(); // cycle 2: still BUSY, no ack yet
    if (dm_stallreq_o !== 1'b0) stall_seen++;
    checks++;
    if (mem_ce_o !== 1'b1) begin
      errors++; $display("FAIL flush_runs: got ce=%b, want 1", mem_ce_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h77778888;
    tick(); // cycle 3: DONE_DM
    mem_ack_i = 1'b0;
    #1;
    if (dm_stallreq_o !== 1'b0) stall_seen++;
    checks++;
    if ({dm_data_o, if_stallreq_o} !== {32'h77778888, 1'b1}) begin
      errors++; $display("FAIL flush_result: got dm=%h ifs=%b, want 77778888 1", dm_data_o, if_stallreq_o);
    end
    checks++;
    if (stall_seen !== 0) begin
      errors++; $display("FAIL flush_no_stall: got %0d stalled samples, want 0", stall_seen);
    end
    tick(); // cycle 4: IDLE grants pending fetch
    tick(); // cycle 5
    checks++;
    if ({mem_ce_o, mem_addr_o, mem_sel_o} !== {1'b1, 32'h108, 4'hF}) begin
      errors++; $display("FAIL flush_fetch_grant: got ce=%b addr=%h sel=%h, want 1 00000108 f",
                         mem_ce_o, mem_addr_o, mem_sel_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 32'h9999AAAA;
    tick(); // cycle 6
    mem_ack_i = 1'b0;
    #1;
    checks++;
    if ({if_data_o, if_stallreq_o} !== {32'h9999AAAA, 1'b0}) begin
      errors++; $display("FAIL flush_fetch_done: got if=%h ifs=%b, want 9999aaaa 0", if_data_o, if_stallreq_o);
    end
    if_ce_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_dm_write();
    test_timeout();
    test_reset_mid_busy();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch port (PC/ROM side) and the data port (MEM stage/RAM side) of the 5-stage core.
- Converts each port's request into a sequenced bus transaction and raises a per-port stall request to the pipeline stall controller until the result is available.
- Sits between the core's rom_*/ram_* ports and the external memory; data accesses take priority over fetches.

Parameters:
- TIMEOUT, 16, max cycles in a BUSY state without mem_ack_i before the transaction is forcibly ended with an error.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- if_ce_i  in  1  fetch request (level)
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched instruction, registered
- if_stallreq_o  out  1  fetch not yet complete
- dm_ce_i  in  1  data request (level)
- dm_we_i  in  1  1 = write
- dm_sel_i  in  4  byte enables
- dm_addr_i  in  32  data address
- dm_data_i  in  32  write data
- dm_data_o  out  32  read data, registered
- dm_stallreq_o  out  1  data access not yet complete
- mem_ce_o  out  1  bus request, registered
- mem_we_o  out  1  bus write, registered
- mem_sel_o  out  4  bus byte enables, registered
- mem_addr_o  out  32  bus address, registered
- mem_data_o  out  32  bus write data, registered
- mem_data_i  in  32  bus read data, valid with ack
- mem_ack_i  in  1  bus completion, one cycle per transaction
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter=0.
  - All mem_* = 0; if_data_o = dm_data_o = 0; bus_err_o = 0.
  - Both stallreqs forced to 0 while rst=0.
- States: IDLE, BUSY_IF, BUSY_DM, DONE_IF, DONE_DM.
- IDLE:
  - If dm_ce_i → BUSY_DM. Else if if_ce_i → BUSY_IF.
  - On the same edge, register the granted port's addr/sel/we/data onto mem_* and set mem_ce_o=1.
  - Fetches use mem_we_o=0 and mem_sel_o=4'b1111.
- BUSY_x:
  - mem_* held stable.
  - If mem_ack_i: latch mem_data_i into x_data_o (only when the access is a read), clear mem_*, → DONE_x.
  - Else if counter == TIMEOUT-1: x_data_o=0, bus_err_o=1 for the DONE cycle, clear mem_*, → DONE_x.
  - Otherwise counter increments. Counter clears on leaving BUSY.
- DONE_x:
  - Lasts one cycle; x_data_o is valid during it.
  - Always → IDLE. Requests seen during DONE_x belong to the completed access and are ignored.
- Stall requests (combinational from state):
  - if_stallreq_o = if_ce_i & (state != DONE_IF).
  - dm_stallreq_o = dm_ce_i & (state != DONE_DM).
- Latency: a request at cycle 0 with the arbiter in IDLE and ack in cycle 1 gives DONE in cycle 2. Stall is high in cycles 0–1.
- Simultaneous requests:
  - Data is served first; fetch remains stalled.
  - The fetch is granted from IDLE after DONE_DM.
- Request dropped mid-transaction (flush):
  - The bus transaction still runs to ack or timeout.
  - The result is latched but no stall is raised; the bus cannot abort.
- mem_ack_i in IDLE or DONE is ignored.
- Write data to dm_data_o: unchanged on writes.
- Reset mid-transaction: immediate return to IDLE, mem_ce_o=0. Any late ack is ignored.

Decomposition:
- Shared defines file holds:
  - state encodings `ArbIdle, `ArbBusyIf, `ArbBusyDm, `ArbDoneIf, `ArbDoneDm (3-bit).
  - `ArbTimeoutDefault.
  - Error data value 32'h0.
- No sub-module; the FSM, counter and output registers form one block.

Test Plan:
- Fetch only, if_addr=0x100, ack in cycle 1 with 0x3C010101:
  - mem_ce_o=1 with addr 0x100 in cycle 1.
  - if_data_o=0x3C010101 and if_stallreq_o=0 in cycle 2.
- Both ports request in cycle 0 (dm read 0x2000, fetch 0x104), ack after 1 cycle each:
  - DM is served first and dm_stallreq_o drops in cycle 2.
  - Fetch appears on the bus in cycle 4; if_stallreq_o drops in cycle 5.
- DM write, addr 0x2004, sel 4'b0011, data 0xA5A5A5A5:
  - Bus shows we=1, sel=0011 and that data.
  - dm_data_o is unchanged.
- No ack, TIMEOUT=16:
  - Exactly 16 BUSY cycles, then a DONE cycle with bus_err_o=1 and if_data_o=0.
  - Arbiter returns to IDLE.
- rst pulled low in the middle of BUSY_DM:
  - All outputs go to 0 asynchronously.
  - An ack arriving after rst releases is ignored and the state stays IDLE.
- dm_ce_i dropped during BUSY_DM:
  - The transaction completes on ack with dm_stallreq_o=0 throughout.
  - A pending fetch is granted after DONE_DM.
